// File: rtl/adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
package adder_pkg;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit combinational adder with carry in and carry out.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

// File: rtl/pipelined_adder.sv
// Carry-chained adder split into STAGES chunks, one chunk added per stage, globally stalled.
// Optional signed-overflow output is enabled by defining ADDER_OVF_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_width_chk
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  // One register per stage: a/b carry the not-yet-added upper chunks (skew),
  // s carries the finished lower chunks (deskew), c is the chunk carry.
  typedef struct packed {
    logic             vld;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  stg_t [STAGES-1:0]            stg_q, stg_d, stg_in;
  logic [STAGES-1:0][CHUNK-1:0] ch_s;
  logic [STAGES-1:0]            ch_co;
  logic                         en;

  assign en       = !stg_q[STAGES-1].vld || out_ready;
  assign in_ready = en;

  always_comb begin
    stg_in        = '0;
    stg_in[0].vld = in_valid;
    stg_in[0].c   = cin;
    stg_in[0].a   = a;
    stg_in[0].b   = b;
    for (int k = 1; k < STAGES; k++) stg_in[k] = stg_q[k-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a  (stg_in[k].a[k*CHUNK +: CHUNK]),
      .b  (stg_in[k].b[k*CHUNK +: CHUNK]),
      .ci (stg_in[k].c),
      .s  (ch_s[k]),
      .co (ch_co[k])
    );
  end

  always_comb begin
    stg_d = stg_q;
    if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_d[k]                     = stg_in[k];
        stg_d[k].s[k*CHUNK +: CHUNK] = ch_s[k];
        stg_d[k].c                   = ch_co[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stg_q <= '0;
    else        stg_q <= stg_d;
  end

  assign out_valid = stg_q[STAGES-1].vld;
  assign sum       = stg_q[STAGES-1].s;
  assign cout      = stg_q[STAGES-1].c;

`ifdef ADDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (en)
      ovf_d = (stg_d[STAGES-1].a[WIDTH-1] == stg_d[STAGES-1].b[WIDTH-1]) &&
              (stg_d[STAGES-1].s[WIDTH-1] != stg_d[STAGES-1].a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4).
module tb_pipelined_adder;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk, rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef ADDER_OVF_EN
  logic         ovf;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow as signed range violation.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    exp_t        e;
    int unsigned t;
    int          sv;
    t   = int'(ia) + int'(ib) + int'(ic);
    e.s = t[W-1:0];
    e.c = t[W];
    sv  = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
    e.o = (sv > 32767) || (sv < -32768);
    return e;
  endfunction

  task automatic step(input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input bit ic, input bit ordy, output bit got);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !out_valid || ordy);
    got = out_valid && out_ready;
    if (got) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
`ifdef ADDER_OVF_EN
        chk("ovf", ovf, e.o);
`endif
      end
    end
    if (iv && in_ready) q.push_back(model(ia, ib, ic));
    @(posedge clk);
  endtask

  task automatic drain();
    bit got;
    for (int n = 0; n < 20 && q.size() != 0; n++) step(0, '0, '0, 0, 1, got);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic lat_beat(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit ic,
                          input logic [W-1:0] es, input bit ec, input bit eo);
    int n;
    @(negedge clk);
    in_valid = 1; a = ia; b = ib; cin = ic; out_ready = 1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      in_valid = 0;
      if (out_valid) begin n = i; break; end
    end
    chk("latency", n, S);
    chk("lat_sum", sum, es);
    chk("lat_cout", cout, ec);
`ifdef ADDER_OVF_EN
    chk("lat_ovf", ovf, eo);
`else
    if (eo) n = n;
`endif
    @(posedge clk); #1;
    chk("lat_clear", out_valid, 0);
  endtask

  initial begin
    bit           got;
    logic [W-1:0] hold;
    clk = 0; rst_n = 0; in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    #15 rst_n = 1;

    lat_beat(16'h00FF, 16'h0001, 0, 16'h0100, 0, 0);
    lat_beat(16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0);
`ifdef ADDER_OVF_EN
    lat_beat(16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
    lat_beat(16'h8000, 16'h8000, 0, 16'h0000, 1, 1);
`endif

    for (int i = 0; i < 100; i++) begin
      step(1, W'($urandom), W'($urandom), 1'($urandom), 1, got);
      if (i >= S) chk("stream_valid", got, 1);
    end
    drain();

    for (int i = 0; i < 8; i++) step(1, W'($urandom), W'($urandom), 1'($urandom), 0, got);
    chk("stall_fill", q.size(), S);
    #1 hold = sum;
    for (int i = 0; i < 10; i++) begin
      step(1, W'($urandom), W'($urandom), 1'($urandom), 0, got);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", sum, hold);
    end
    for (int i = 0; i < 80; i++)
      step(($urandom % 4) != 0, W'($urandom), W'($urandom), 1'($urandom), ($urandom % 3) != 0, got);
    drain();

    for (int i = 0; i < 5; i++) step(1, W'($urandom), W'($urandom), 1'($urandom), 1, got);
    #1 chk("pre_rst_valid", out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    q.delete();
    in_valid = 0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1;
    lat_beat(16'h1234, 16'h4321, 1, 16'h5556, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
